// File: rtl/stream_ingest_buffer_if.sv
// Handshake and status bundle between the upstream feeder and stream_ingest_buffer.
// The slave view is the buffer itself; the master view is whoever drives samples in.
interface stream_ingest_buffer_if #(
   parameter int DEPTH = 16
);
   logic [63:0]            in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [63:0]            data_out;
   logic                   out_valid;
   logic [$clog2(DEPTH):0] fill_level;
   logic [31:0]            underflow_count;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  data_out,
      input  out_valid,
      input  fill_level,
      input  underflow_count
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output data_out,
      output out_valid,
      output fill_level,
      output underflow_count
   );
endinterface

// File: rtl/stream_ingest_buffer.sv
// Ingest FIFO feeding DataStreamProcessor: primes to PRIME_LEVEL, then emits one word per clock.
// Underflow produces the zero marker; genuine zero samples are clamped to 1 on entry.
module stream_ingest_buffer #(
   parameter int DEPTH       = 16,
   parameter int PRIME_LEVEL = 4,
   parameter int MAX_GAP     = 8
) (
   input logic                   clk,
   input logic                   reset,
   stream_ingest_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(MAX_GAP + 1);

   localparam logic [0:0] ST_PRIME  = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   localparam logic [AW:0]   FULL_LVL  = DEPTH[AW:0];
   localparam logic [AW:0]   PRIME_LVL = PRIME_LEVEL[AW:0];
   localparam logic [GW-1:0] GAP_LIMIT = MAX_GAP[GW-1:0];

   // A zero sample would be indistinguishable from a dropout marker downstream.
   function automatic logic [63:0] clamp_zero(input logic [63:0] word);
      logic [63:0] res;
      if (word == 64'd0) begin
         res = 64'd1;
      end else begin
         res = word;
      end
      return res;
   endfunction

   logic [63:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   cnt_r;
   logic [0:0]    state_r;
   logic [GW-1:0] gap_r;
   logic [63:0]   data_out_r;
   logic          out_valid_r;
   logic [31:0]   underflow_r;

   logic          full_s;
   logic          push_s;
   logic          pop_s;
   logic          underflow_s;
   logic [0:0]    state_nxt_s;
   logic [GW-1:0] gap_nxt_s;
   logic [GW-1:0] gap_inc_s;
   logic [63:0]   data_nxt_s;
   logic          valid_nxt_s;
   logic [AW:0]   cnt_nxt_s;

   assign full_s    = (cnt_r == FULL_LVL);
   assign gap_inc_s = gap_r + GW'(1);

   // Next-state decode: pop/underflow decisions come from the pre-edge occupancy only (no bypass).
   always_comb begin
      push_s      = bus.in_valid && !full_s;
      pop_s       = 1'b0;
      underflow_s = 1'b0;
      state_nxt_s = state_r;
      gap_nxt_s   = gap_r;
      data_nxt_s  = 64'd0;
      valid_nxt_s = 1'b0;
      case (state_r)
         ST_PRIME: begin
            if (cnt_r >= PRIME_LVL) begin
               pop_s       = 1'b1;
               state_nxt_s = ST_STREAM;
               data_nxt_s  = mem_r[rd_ptr_r];
               valid_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_PRIME;
            end
         end
         ST_STREAM: begin
            valid_nxt_s = 1'b1;
            if (cnt_r != {(AW + 1){1'b0}}) begin
               pop_s      = 1'b1;
               data_nxt_s = mem_r[rd_ptr_r];
               gap_nxt_s  = {GW{1'b0}};
            end else begin
               underflow_s = 1'b1;
               if (gap_inc_s == GAP_LIMIT) begin
                  state_nxt_s = ST_PRIME;
                  valid_nxt_s = 1'b0;
                  gap_nxt_s   = {GW{1'b0}};
               end else begin
                  gap_nxt_s = gap_inc_s;
               end
            end
         end
         default: begin
            state_nxt_s = ST_PRIME;
            gap_nxt_s   = {GW{1'b0}};
         end
      endcase
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + (AW + 1)'(1);
         2'b01:   cnt_nxt_s = cnt_r - (AW + 1)'(1);
         default: cnt_nxt_s = cnt_r;
      endcase
   end

   // Storage array; stale contents are harmless because reset clears the pointers and count.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= clamp_zero(bus.in_data);
      end
   end

   // Pointers, occupancy, FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_PRIME;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         cnt_r       <= {(AW + 1){1'b0}};
         gap_r       <= {GW{1'b0}};
         data_out_r  <= 64'd0;
         out_valid_r <= 1'b0;
         underflow_r <= 32'd0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         gap_r       <= gap_nxt_s;
         data_out_r  <= data_nxt_s;
         out_valid_r <= valid_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         if (underflow_s && (underflow_r != 32'hFFFF_FFFF)) begin
            underflow_r <= underflow_r + 32'd1;
         end
      end
   end

   assign bus.in_ready        = !full_s;
   assign bus.fill_level      = cnt_r;
   assign bus.data_out        = data_out_r;
   assign bus.out_valid       = out_valid_r;
   assign bus.underflow_count = underflow_r;
endmodule

// File: doc/stream_ingest_buffer.md
# stream_ingest_buffer

Upstream feeder for `DataStreamProcessor`. Accepts bursty 64-bit samples over a valid/ready handshake, buffers them in a FIFO, and emits exactly one word per clock on `data_out` once primed. A FIFO underflow is emitted as the zero "missing sample" marker that the processor interpolates over. A legitimate input value of 0 is clamped to 1, so a zero on `data_out` always means a real dropout.

## Interface
- `DEPTH`, 16 — FIFO depth in words; power of 2, ≥ 4.
- `PRIME_LEVEL`, 4 — FIFO occupancy required before streaming starts; range 1..DEPTH.
- `MAX_GAP`, 8 — consecutive underflow cycles that force a return to priming; ≥ 1.
- `clk` in 1 — single clock; all logic is rising-edge.
- `reset` in 1 — synchronous, active-high; sampled on the rising edge of `clk`.
- `in_data` in 64 — upstream sample.
- `in_valid` in 1 — `in_data` is valid.
- `in_ready` out 1 — block can accept a word this cycle.
- `data_out` out 64 — sample to `DataStreamProcessor.data_in`; registered.
- `out_valid` out 1 — `data_out` is part of the live stream; registered.
- `fill_level` out $clog2(DEPTH)+1 — current FIFO occupancy.
- `underflow_count` out 32 — total zero markers emitted; saturating.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers and an occupancy counter `cnt` ranging 0..DEPTH.
  - `fill_level` = `cnt`; `in_ready` = (`cnt` != DEPTH), decoded from the registered `cnt`.
- **Push**
  - Occurs when `in_valid && in_ready`.
  - Stored word = `in_data`, or 64'd1 if `in_data` == 0.
- **State machine:** two states, `PRIME` and `STREAM`.
- **PRIME** (the reset state):
  - No pops. `data_out` <= 0, `out_valid` <= 0.
  - If `cnt` (pre-edge) ≥ `PRIME_LEVEL`:
    - Go to `STREAM`.
    - Pop the head word on the same edge: `data_out` <= head, `out_valid` <= 1.
- **STREAM**, every edge:
  - If `cnt` > 0:
    - Pop: `data_out` <= head, `out_valid` <= 1.
    - Clear the gap counter.
  - If `cnt` == 0:
    - `data_out` <= 0, `out_valid` <= 1.
    - `underflow_count` += 1 (saturates at 2^32-1).
    - Gap counter += 1.
    - If the gap counter reaches `MAX_GAP`: go to `PRIME`, set `out_valid` <= 0 on that same edge, and clear the gap counter.
- **Simultaneous push and pop:** `cnt` is unchanged and pointers advance independently.
  - A push while `cnt` == DEPTH is impossible, because `in_ready` is 0 that cycle even if a pop also occurs.
- **No bypass:** a word pushed into an empty FIFO is never popped on the same edge.
- **Arithmetic:**
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - `cnt` never exceeds DEPTH or goes below 0.

## Timing
- **Reset values:** `data_out` = 0, `out_valid` = 0, `in_ready` = 1 (FIFO empty), `fill_level` = 0, `underflow_count` = 0, state = `PRIME`, pointers and gap counter = 0.
- **Reset mid-operation:** all FIFO contents are discarded and every output returns to its reset value on that edge.
- **Latency:**
  - A word accepted at edge k is, at the earliest, on `data_out` after edge k+1.
  - When priming, it appears after the edge on which `cnt` first reaches `PRIME_LEVEL`, plus one.
- **Throughput:**
  - Input: one word per cycle.
  - Output: exactly one word per cycle while in `STREAM`.
- **In `PRIME`:** `data_out` is held at 0 and `out_valid` is 0. The downstream processor sees 0s but must ignore them via `out_valid`.

## Test plan
- **Reset defaults:** assert `reset` for 2 cycles with `in_valid`=1, then release. Required: during reset, `in_ready`=1, `fill_level`=0, `out_valid`=0, `data_out`=0, and no words are stored.
- **Prime then stream:** `PRIME_LEVEL`=4; push 1000, 5000, 3000, 4000 on consecutive cycles.
  - `out_valid` rises one edge after the 4th push, with `data_out`=1000.
  - Next cycles give 5000, 3000, 4000, then 0 with `underflow_count`=1.
- **Zero clamp:** push 0 mid-stream between 3000 and 5000. Required: `data_out` sequence 3000, 1, 5000; `underflow_count` unchanged.
- **Full FIFO:** hold `in_valid`=1 with `PRIME_LEVEL`=DEPTH=16. Required:
  - `in_ready` drops after 16 accepts.
  - On the next edge: state becomes `STREAM`, one pop occurs, `fill_level`=15, `in_ready`=1.
  - With `in_valid` still high, a push and pop per cycle hold `fill_level` at 15 with no loss or duplication.
- **Gap re-prime:** `MAX_GAP`=8; stop input after streaming. Required:
  - 7 cycles of `data_out`=0 with `out_valid`=1.
  - On the 8th underflow edge: `out_valid`=0 and state=`PRIME`.
  - `underflow_count`=8.
  - Resumed input re-primes before streaming again.
- **Reset mid-stream:** reset with `fill_level`=6. Required: `fill_level`=0, `underflow_count`=0, `out_valid`=0 the next cycle; old words never appear on `data_out`.
